cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Miss-handling FSM downstream of the replacement-way generator.
- On a cache miss it takes the victim one-hot way from the generator and writes back the victim line if it is valid and dirty.
- It then burst-reads the missing line from the bus bridge and writes it word-by-word into data RAM, then updates the tag/valid/dirty entry.
- One instance per cache (I and D).

Parameters:
- NUM_WAY, 2, number of ways; must match the replacement-way generator.
- INDEX_WIDTH, 8, set index bits.
- OFFSET_WIDTH, 4, byte offset bits. Line has WORDS = 2^(OFFSET_WIDTH-2) 32-bit words.
- TAG_WIDTH, 20, equals 32-INDEX_WIDTH-OFFSET_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- miss_valid  in  1  miss request.
- miss_ready  out  1  controller idle, accepts miss.
- miss_addr  in  32  missing physical address.
- v_ways  in  NUM_WAY  valid bits of the indexed set.
- d_ways  in  NUM_WAY  dirty bits of the indexed set.
- tag_ways  in  NUM_WAY*TAG_WIDTH  tags of the indexed set; way i at [i*TAG_WIDTH +: TAG_WIDTH].
- replace_way  in  NUM_WAY  one-hot victim from the generator.
- replace_en  out  1  one-cycle pulse advancing the generator.
- line_rd_en  out  1  data RAM whole-line read strobe.
- line_rd_way  out  NUM_WAY  one-hot way for the line read.
- line_rd_index  out  INDEX_WIDTH  set for the line read.
- line_rd_data  in  32*WORDS  line data, valid one cycle after line_rd_en.
- wr_req  out  1  write-back request.
- wr_addr  out  32  write-back line address, offset bits zero.
- wr_data  out  32*WORDS  write-back line; word 0 in [31:0].
- wr_rdy  in  1  bridge accepts write.
- rd_req  out  1  refill read request.
- rd_addr  out  32  refill line address, offset bits zero.
- rd_rdy  in  1  bridge accepts read.
- ret_valid  in  1  refill word valid.
- ret_last  in  1  last refill word.
- ret_data  in  32  refill word.
- refill_we  out  1  data RAM word write enable.
- refill_way  out  NUM_WAY  one-hot way written.
- refill_index  out  INDEX_WIDTH  set written.
- refill_word  out  OFFSET_WIDTH-2  word offset written.
- refill_data  out  32  word written.
- tag_we  out  1  tag/valid/dirty write; writes tag=miss tag, v=1, d=0.
- done  out  1  one-cycle pulse, refill complete.

Behaviour:
- States: IDLE, SELECT, WB_READ, WB_REQ, RD_REQ, REFILL, DONE. Encoding is free.
- resetn low forces IDLE asynchronously from any state, including mid-burst; registers clear to 0. Every output is 0 in reset except miss_ready, which is 1 because it decodes IDLE.
- All outputs are decoded from state and registers (Moore), except that refill_we/refill_data follow ret_valid/ret_data combinationally in REFILL.
- IDLE:
  - miss_ready=1.
  - On miss_valid, register miss_addr, v_ways, d_ways, tag_ways, then go to SELECT.
- SELECT (1 cycle):
  - Register victim=replace_way and pulse replace_en=1.
  - dirty_victim = |(replace_way & v_ways & d_ways).
  - Go to WB_READ if dirty_victim, else RD_REQ.
  - replace_way must be one-hot; a non-one-hot value is a checker error.
- WB_READ (1 cycle):
  - line_rd_en=1, line_rd_way=victim, line_rd_index=addr index.
  - Go to WB_REQ. On entry, capture line_rd_data into the wb buffer.
- WB_REQ:
  - wr_req=1, wr_addr={victim tag, index, 0}, wr_data=wb buffer.
  - Outputs are held stable until the cycle wr_req&wr_rdy, then go to RD_REQ.
- RD_REQ:
  - rd_req=1, rd_addr={addr[31:OFFSET_WIDTH], 0}, held until rd_req&rd_rdy.
  - On that handshake, clear word counter to 0 and go to REFILL.
- REFILL:
  - Each ret_valid cycle: refill_we=1, refill_way=victim, refill_index=addr index, refill_word=counter, refill_data=ret_data; counter increments and wraps at WORDS.
  - On ret_valid&ret_last, tag_we=1 in the same cycle, then go to DONE.
  - ret_valid=0 cycles produce no writes.
  - ret_last with counter≠WORDS-1 is a protocol violation: the checker flags it; RTL still goes to DONE.
- DONE (1 cycle): done=1, then IDLE. A new miss is accepted no earlier than the cycle after DONE.
- Latency, clean victim and all handshakes/returns ready immediately: done asserts 3+WORDS cycles after acceptance.
- A dirty victim adds 2 cycles.
- Bridge signals arriving in an unrelated state are ignored.

Test Plan:
- Clean miss: v=2'b01, d=2'b00, replace_way=2'b10, addr 0x1234_5678, 4 returns 0xA0..0xA3 with last on 4th -> no wr_req; rd_addr=0x1234_5670; refill_word 0..3, way 2'b10; tag_we with 4th word; done at cycle 7.
- Dirty write-back: v=2'b11, d=2'b01, replace_way=2'b01, tag0=0x000AB -> WB_READ line_rd_en one cycle.
  - wr_addr={0x000AB, index, 4'h0}.
  - wr_data equals line_rd_data.
  - rd_req only after wr_rdy.
- Backpressure: wr_rdy low 5 cycles, rd_rdy low 3 cycles, ret_valid gaps -> wr_*/rd_* stable while waiting; no refill_we in gap cycles; exactly 4 writes.
- Victim valid but clean (v=2'b11, d=2'b10, replace_way=2'b01) -> no write-back; replace_en exactly one pulse per miss.
- Reset mid-REFILL after 2 words: resetn low asynchronously -> outputs 0, miss_ready=1; the next miss proceeds normally with counter starting at 0.
- Early ret_last on word 1 -> checker flags violation; FSM reaches DONE then IDLE.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle for cache_refill_ctrl: miss request, set snapshot, replacement-way
// generator, data RAM line read/word write, tag write and the bus bridge
// read/write channels.
//   master : the refill controller (drives strobes, addresses, write data).
//   slave  : the cache/bridge side (drives miss request, RAM data, handshakes).
// proto_err is a one-cycle flag for a non-one-hot victim or an early ret_last.
interface cache_refill_ctrl_if #(
    parameter int unsigned NUM_WAY      = 2,
    parameter int unsigned INDEX_WIDTH  = 8,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
);
    localparam int unsigned WORDS = 32'd1 << (OFFSET_WIDTH - 2);

    logic                          miss_valid;
    logic                          miss_ready;
    logic [31:0]                   miss_addr;
    logic [NUM_WAY-1:0]            v_ways;
    logic [NUM_WAY-1:0]            d_ways;
    logic [NUM_WAY*TAG_WIDTH-1:0]  tag_ways;
    logic [NUM_WAY-1:0]            replace_way;
    logic                          replace_en;
    logic                          line_rd_en;
    logic [NUM_WAY-1:0]            line_rd_way;
    logic [INDEX_WIDTH-1:0]        line_rd_index;
    logic [32*WORDS-1:0]           line_rd_data;
    logic                          wr_req;
    logic [31:0]                   wr_addr;
    logic [32*WORDS-1:0]           wr_data;
    logic                          wr_rdy;
    logic                          rd_req;
    logic [31:0]                   rd_addr;
    logic                          rd_rdy;
    logic                          ret_valid;
    logic                          ret_last;
    logic [31:0]                   ret_data;
    logic                          refill_we;
    logic [NUM_WAY-1:0]            refill_way;
    logic [INDEX_WIDTH-1:0]        refill_index;
    logic [OFFSET_WIDTH-3:0]       refill_word;
    logic [31:0]                   refill_data;
    logic                          tag_we;
    logic                          done;
    logic                          proto_err;

    modport master (
        input  miss_valid, miss_addr, v_ways, d_ways, tag_ways, replace_way, line_rd_data,
               wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        output miss_ready, replace_en, line_rd_en, line_rd_way, line_rd_index, wr_req, wr_addr,
               wr_data, rd_req, rd_addr, refill_we, refill_way, refill_index, refill_word,
               refill_data, tag_we, done, proto_err
    );

    modport slave (
        output miss_valid, miss_addr, v_ways, d_ways, tag_ways, replace_way, line_rd_data,
               wr_rdy, rd_rdy, ret_valid, ret_last, ret_data,
        input  miss_ready, replace_en, line_rd_en, line_rd_way, line_rd_index, wr_req, wr_addr,
               wr_data, rd_req, rd_addr, refill_we, refill_way, refill_index, refill_word,
               refill_data, tag_we, done, proto_err
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss-handling controller. Accepts a miss, takes the one-hot victim from
// the replacement-way generator, writes the victim line back when it is valid
// and dirty, burst-reads the missing line and writes it word by word into the
// data RAM, then strobes the tag/valid/dirty update.
// Ports:
//   clk    : clock, rising edge.
//   resetn : asynchronous active-low reset.
//   bus    : cache_refill_ctrl_if.master (miss, set snapshot, RAM, bridge, status).
module cache_refill_ctrl #(
    parameter int unsigned NUM_WAY      = 2,
    parameter int unsigned INDEX_WIDTH  = 8,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input logic                clk,
    input logic                resetn,
    cache_refill_ctrl_if.master bus
);
    localparam int unsigned WORDS  = 32'd1 << (OFFSET_WIDTH - 2);
    localparam int unsigned WORD_W = OFFSET_WIDTH - 2;
    localparam int unsigned LINE_W = 32 - OFFSET_WIDTH;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SELECT  = 3'd1;
    localparam logic [2:0] WB_READ = 3'd2;
    localparam logic [2:0] WB_REQ  = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] REFILL  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]                   state_q, state_d;
    logic [LINE_W-1:0]            line_q, line_d;    // miss address without offset
    logic [NUM_WAY-1:0]           v_q, v_d;
    logic [NUM_WAY-1:0]           d_q, d_d;
    logic [NUM_WAY*TAG_WIDTH-1:0] tags_q, tags_d;
    logic [NUM_WAY-1:0]           victim_q, victim_d;
    logic [32*WORDS-1:0]          wb_q, wb_d;
    logic [WORD_W-1:0]            cnt_q, cnt_d;

    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   victim_tag;
    logic                   dirty_victim;
    logic                   way_onehot;
    logic                   in_refill;
    logic                   unused_offset;

    assign index        = line_q[INDEX_WIDTH-1:0];
    assign dirty_victim = |(bus.replace_way & v_q & d_q);
    assign way_onehot   = (bus.replace_way != '0) &&
                          ((bus.replace_way & (bus.replace_way - NUM_WAY'(1))) == '0);
    assign in_refill    = (state_q == REFILL);
    // Offset bits of the miss address never matter: the line is fetched whole.
    assign unused_offset = ^bus.miss_addr[OFFSET_WIDTH-1:0];

    always_comb begin
        victim_tag = '0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (victim_q[i]) begin
                victim_tag = victim_tag | tags_q[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        v_d      = v_q;
        d_d      = d_q;
        tags_d   = tags_q;
        victim_d = victim_q;
        wb_d     = wb_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.miss_valid) begin
                    line_d  = bus.miss_addr[31:OFFSET_WIDTH];
                    v_d     = bus.v_ways;
                    d_d     = bus.d_ways;
                    tags_d  = bus.tag_ways;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                victim_d = bus.replace_way;
                state_d  = dirty_victim ? WB_READ : RD_REQ;
            end
            WB_READ: begin
                wb_d    = bus.line_rd_data;
                state_d = WB_REQ;
            end
            WB_REQ: begin
                if (bus.wr_rdy) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.rd_rdy) begin
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.ret_valid) begin
                    cnt_d = cnt_q + WORD_W'(1);
                    if (bus.ret_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            line_q   <= '0;
            v_q      <= '0;
            d_q      <= '0;
            tags_q   <= '0;
            victim_q <= '0;
            wb_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            v_q      <= v_d;
            d_q      <= d_d;
            tags_q   <= tags_d;
            victim_q <= victim_d;
            wb_q     <= wb_d;
            cnt_q    <= cnt_d;
        end
    end

    // Address/data outputs are gated by their state so the bus is quiet when idle.
    always_comb begin
        bus.miss_ready    = (state_q == IDLE);
        bus.replace_en    = (state_q == SELECT);
        bus.line_rd_en    = (state_q == WB_READ);
        bus.line_rd_way   = (state_q == WB_READ) ? victim_q : '0;
        bus.line_rd_index = (state_q == WB_READ) ? index : '0;
        bus.wr_req        = (state_q == WB_REQ);
        bus.wr_addr       = (state_q == WB_REQ) ?
                            {victim_tag, index, {OFFSET_WIDTH{1'b0}}} : '0;
        bus.wr_data       = (state_q == WB_REQ) ? wb_q : '0;
        bus.rd_req        = (state_q == RD_REQ);
        bus.rd_addr       = (state_q == RD_REQ) ? {line_q, {OFFSET_WIDTH{1'b0}}} : '0;
        bus.refill_we     = in_refill && bus.ret_valid;
        bus.refill_way    = in_refill ? victim_q : '0;
        bus.refill_index  = in_refill ? index : '0;
        bus.refill_word   = in_refill ? cnt_q : '0;
        bus.refill_data   = in_refill ? bus.ret_data : '0;
        bus.tag_we        = in_refill && bus.ret_valid && bus.ret_last;
        bus.done          = (state_q == DONE);
        // Early last: the burst ended before the counter reached the final word.
        bus.proto_err     = ((state_q == SELECT) && !way_onehot) ||
                            (in_refill && bus.ret_valid && bus.ret_last && !(&cnt_q));
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
    localparam int unsigned NUM_WAY      = 2;
    localparam int unsigned INDEX_WIDTH  = 8;
    localparam int unsigned OFFSET_WIDTH = 4;
    localparam int unsigned TAG_WIDTH    = 20;
    localparam int unsigned WORDS        = 4;
    localparam int unsigned OUTS_W       = 8 + 2*NUM_WAY + 2*INDEX_WIDTH + 3*32 + 32*WORDS +
                                           (OFFSET_WIDTH - 2);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl_if #(
        .NUM_WAY(NUM_WAY), .INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) bus ();

    cache_refill_ctrl #(
        .NUM_WAY(NUM_WAY), .INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    function automatic logic [OUTS_W-1:0] all_outs();
        return {bus.replace_en, bus.line_rd_en, bus.line_rd_way, bus.line_rd_index, bus.wr_req,
                bus.wr_addr, bus.wr_data, bus.rd_req, bus.rd_addr, bus.refill_we, bus.refill_way,
                bus.refill_index, bus.refill_word, bus.refill_data, bus.tag_we, bus.done,
                bus.proto_err};
    endfunction

    task automatic drive_idle();
        bus.miss_valid = 1'b0;
        bus.wr_rdy     = 1'b0;
        bus.rd_rdy     = 1'b0;
        bus.ret_valid  = 1'b0;
        bus.ret_last   = 1'b0;
        bus.ret_data   = '0;
    endtask

    // One miss against a reactive bridge model. Expectations come from the
    // behavioural rules: victim dirty iff valid&dirty, addresses from tag/index,
    // words in order, and an arithmetic latency budget.
    task automatic run_miss(input string name, input logic [31:0] addr,
                            input logic [NUM_WAY-1:0] v, input logic [NUM_WAY-1:0] d,
                            input logic [NUM_WAY-1:0] rway,
                            input logic [NUM_WAY*TAG_WIDTH-1:0] tags, input int ws, input int rs,
                            input int max_gap, input int nret, input int abort_after,
                            input bit fixed_data);
        logic                   dirty;
        logic [TAG_WIDTH-1:0]   vtag;
        logic [INDEX_WIDTH-1:0] idx;
        logic [31:0]            exp_wr_addr, exp_rd_addr;
        logic [32*WORDS-1:0]    line;
        logic [31:0]            bdata[$];
        int                     gaps[$];
        int exp_done, total_gaps, cyc, wr_wait, rd_wait, beat, gap_left;
        int n_rep, n_lre, n_wr, n_we, n_tag, n_done, done_cyc;
        bit wr_done, in_refill, stop, aborted, exp_perr;

        dirty = |(rway & v & d);
        vtag  = '0;
        for (int i = 0; i < NUM_WAY; i++) if (rway[i]) vtag = tags[i*TAG_WIDTH +: TAG_WIDTH];
        idx         = addr[OFFSET_WIDTH +: INDEX_WIDTH];
        exp_wr_addr = {vtag, idx, 4'h0};
        exp_rd_addr = {addr[31:4], 4'h0};
        line        = {$urandom, $urandom, $urandom, $urandom};
        total_gaps  = 0;
        for (int b = 0; b < nret; b++) begin
            gaps.push_back((max_gap > 0 && (b % 2) == 1) ? int'($urandom_range(max_gap, 1)) : 0);
            total_gaps += gaps[b];
            bdata.push_back(fixed_data ? 32'hA0 + 32'(b) : $urandom);
        end
        exp_done = 3 + rs + nret + total_gaps + (dirty ? 2 + ws : 0);

        cyc = 0; wr_wait = 0; rd_wait = 0; beat = 0; gap_left = 0;
        n_rep = 0; n_lre = 0; n_wr = 0; n_we = 0; n_tag = 0; n_done = 0; done_cyc = -1;
        wr_done = 0; in_refill = 0; stop = 0; aborted = 0;

        bus.miss_addr    = addr;
        bus.v_ways       = v;
        bus.d_ways       = d;
        bus.tag_ways     = tags;
        bus.replace_way  = rway;
        bus.line_rd_data = line;

        while (!stop && cyc < 200) begin
            @(negedge clk);
            bus.miss_valid = (cyc == 0);
            if (cyc == 1) bus.miss_addr = $urandom;
            bus.wr_rdy    = bus.wr_req && (wr_wait >= ws);
            bus.rd_rdy    = bus.rd_req && (rd_wait >= rs);
            bus.ret_valid = 1'b0;
            bus.ret_last  = 1'b0;
            bus.ret_data  = $urandom;
            if (in_refill && beat < nret) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    bus.ret_valid = 1'b1;
                    bus.ret_last  = (beat == nret - 1);
                    bus.ret_data  = bdata[beat];
                end
            end
            #1;
            checks++;
            if (bus.miss_ready !== (cyc == 0)) begin
                errors++;
                $display("FAIL %s miss_ready cyc %0d: got %b want %b", name, cyc,
                         bus.miss_ready, (cyc == 0));
            end
            if (bus.replace_en) begin
                n_rep++;
                checks++;
                if (cyc != 1) begin
                    errors++;
                    $display("FAIL %s replace_en cycle: got %0d want 1", name, cyc);
                end
            end
            if (bus.line_rd_en) begin
                n_lre++;
                checks++;
                if (bus.line_rd_way !== rway || bus.line_rd_index !== idx) begin
                    errors++;
                    $display("FAIL %s line_rd way/index: got %b/%h want %b/%h", name,
                             bus.line_rd_way, bus.line_rd_index, rway, idx);
                end
            end
            if (bus.wr_req) begin
                checks++;
                if (dirty !== 1'b1 || bus.wr_addr !== exp_wr_addr || bus.wr_data !== line) begin
                    errors++;
                    $display("FAIL %s wr_req dirty=%b addr got %h want %h data got %h want %h",
                             name, dirty, bus.wr_addr, exp_wr_addr, bus.wr_data, line);
                end
                if (bus.wr_rdy) begin
                    n_wr++;
                    wr_done = 1;
                end else begin
                    wr_wait++;
                end
            end
            if (bus.rd_req) begin
                checks++;
                if (bus.rd_addr !== exp_rd_addr || wr_done !== dirty) begin
                    errors++;
                    $display("FAIL %s rd_req addr got %h want %h wb_done got %b want %b", name,
                             bus.rd_addr, exp_rd_addr, wr_done, dirty);
                end
                if (bus.rd_rdy) begin
                    in_refill = 1;
                    gap_left  = gaps[0];
                end else begin
                    rd_wait++;
                end
            end
            exp_perr = bus.ret_valid && bus.ret_last && ((beat % WORDS) != WORDS - 1);
            checks++;
            if (bus.refill_we !== bus.ret_valid || bus.proto_err !== exp_perr) begin
                errors++;
                $display("FAIL %s refill_we/proto_err cyc %0d: got %b/%b want %b/%b", name, cyc,
                         bus.refill_we, bus.proto_err, bus.ret_valid, exp_perr);
            end
            if (bus.tag_we) n_tag++;
            if (bus.ret_valid) begin
                checks++;
                if (bus.refill_way !== rway || bus.refill_index !== idx ||
                    bus.refill_word !== 2'(beat % WORDS) || bus.refill_data !== bdata[beat] ||
                    bus.tag_we !== bus.ret_last) begin
                    errors++;
                    $display("FAIL %s refill beat %0d: got way %b idx %h word %0d data %h tag_we %b want way %b idx %h word %0d data %h tag_we %b",
                             name, beat, bus.refill_way, bus.refill_index, bus.refill_word,
                             bus.refill_data, bus.tag_we, rway, idx, beat % WORDS, bdata[beat],
                             bus.ret_last);
                end
                n_we++;
                beat++;
                if (beat < nret) gap_left = gaps[beat];
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                stop     = 1;
            end
            if (abort_after > 0 && n_we == abort_after) begin
                resetn = 1'b0;
                #1;
                checks++;
                if (all_outs() !== '0 || bus.miss_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s async reset outputs: got %h ready %b want 0 ready 1", name,
                             all_outs(), bus.miss_ready);
                end
                aborted = 1;
                stop    = 1;
            end
            cyc++;
        end

        drive_idle();
        if (aborted) begin
            @(negedge clk);
            resetn = 1'b1;
            return;
        end

        checks++;
        if (n_rep != 1 || n_lre != int'(dirty) || n_wr != int'(dirty)) begin
            errors++;
            $display("FAIL %s pulse counts: got rep %0d lre %0d wr %0d want 1 %0d %0d", name,
                     n_rep, n_lre, n_wr, dirty, dirty);
        end
        checks++;
        if (n_we != nret || n_tag != 1 || n_done != 1) begin
            errors++;
            $display("FAIL %s write counts: got we %0d tag %0d done %0d want %0d 1 1", name,
                     n_we, n_tag, n_done, nret);
        end
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done latency: got %0d want %0d", name, done_cyc, exp_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.miss_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s back to idle: got ready %b done %b want 1 0", name,
                     bus.miss_ready, bus.done);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        bus.miss_valid   = 1'b1;
        bus.ret_valid    = 1'b1;
        bus.ret_last     = 1'b1;
        bus.ret_data     = 32'hDEAD_BEEF;
        bus.miss_addr    = 32'hFFFF_FFFF;
        bus.v_ways       = '1;
        bus.d_ways       = '1;
        bus.tag_ways     = '1;
        bus.replace_way  = 2'b01;
        bus.line_rd_data = '1;
        #12;
        checks++;
        if (all_outs() !== '0 || bus.miss_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset outputs: got %h ready %b want 0 ready 1", all_outs(),
                     bus.miss_ready);
        end
        drive_idle();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.miss_ready !== 1'b1 || all_outs() !== '0) begin
            errors++;
            $display("FAIL reset release idle: got ready %b outs %h want 1 0", bus.miss_ready,
                     all_outs());
        end
    endtask

    task automatic test_clean_miss();
        run_miss("clean_miss", 32'h1234_5678, 2'b01, 2'b00, 2'b10, {20'h11111, 20'h22222},
                 0, 0, 0, WORDS, 0, 1'b1);
    endtask

    task automatic test_dirty_writeback();
        run_miss("dirty_wb", $urandom, 2'b11, 2'b01, 2'b01, {20'h55555, 20'h000AB},
                 0, 0, 0, WORDS, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_miss("backpressure", $urandom, 2'b11, 2'b10, 2'b10, {20'($urandom), 20'h0F0F0},
                 5, 3, 2, WORDS, 0, 1'b0);
    endtask

    task automatic test_clean_valid_victim();
        run_miss("valid_clean", $urandom, 2'b11, 2'b10, 2'b01, {20'hABCDE, 20'h13579},
                 0, 0, 0, WORDS, 0, 1'b0);
    endtask

    task automatic test_reset_mid_refill();
        run_miss("reset_mid", $urandom, 2'b01, 2'b00, 2'b10, {20'h1, 20'h2},
                 0, 0, 0, WORDS, 2, 1'b0);
        run_miss("after_reset", 32'h0BAD_F00D, 2'b10, 2'b10, 2'b10, {20'h77777, 20'h88888},
                 1, 1, 0, WORDS, 0, 1'b1);
    endtask

    task automatic test_early_last();
        run_miss("early_last", $urandom, 2'b00, 2'b00, 2'b01, {20'h3, 20'h4},
                 0, 0, 0, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [NUM_WAY-1:0] rway;
        for (int n = 0; n < 20; n++) begin
            rway = 2'b01 << $urandom_range(1, 0);
            run_miss("random", $urandom, 2'($urandom), 2'($urandom), rway,
                     {20'($urandom), 20'($urandom)}, int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), WORDS, 0, 1'b0);
        end
    endtask

    initial begin
        drive_idle();
        resetn = 1'b0;
        test_reset();
        test_clean_miss();
        test_dirty_writeback();
        test_backpressure();
        test_clean_valid_victim();
        test_reset_mid_refill();
        test_early_last();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
